// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode/write-back slice: instruction
// codes, register IDs, status codes and the pipeline-register bubble value.
package y86_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 15;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [XLEN-1:0] val_c;
    logic [XLEN-1:0] val_p;
    logic [2:0]      stat;
  } d_reg_t;

  // A bubble is a NOP that names no registers, so it reads and writes nothing.
  localparam d_reg_t D_BUBBLE = '{
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    val_c: {XLEN{1'b0}},
    val_p: {XLEN{1'b0}},
    stat:  S_AOK
  };

endpackage

// File: rtl/y86_regfile.sv
// Program register file: 15 x 64-bit, two combinational read ports, two
// write ports updated on the rising edge. Reads see same-cycle write data,
// and the M port beats the E port so that popq %rsp loads the popped value.
module y86_regfile
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  output logic [XLEN-1:0] val_a,
  output logic [XLEN-1:0] val_b,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m
);

  logic [XLEN-1:0] regs [NREGS];

  // Register storage: cleared by reset, otherwise written from both ports
  // with M taking precedence. ID 0xF never matches an index, so it is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (dst_m == 4'(i)) begin
          regs[i] <= val_m;
        end else if (dst_e == 4'(i)) begin
          regs[i] <= val_e;
        end
      end
    end
  end

  // Read port A: stored value, overridden by incoming write-back data.
  always_comb begin
    val_a = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_a == 4'(i)) begin
        val_a = regs[i];
      end
    end
    if (!reset && src_a != RNONE) begin
      if (src_a == dst_m) begin
        val_a = val_m;
      end else if (src_a == dst_e) begin
        val_a = val_e;
      end
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    val_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_b == 4'(i)) begin
        val_b = regs[i];
      end
    end
    if (!reset && src_b != RNONE) begin
      if (src_b == dst_m) begin
        val_b = val_m;
      end else if (src_b == dst_e) begin
        val_b = val_e;
      end
    end
  end

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode / write-back stage. Holds the F->D pipeline register,
// decodes the source and destination register IDs, and reads the operands
// from the register file, which the W stage writes every cycle.
module y86_decode_stage
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      f_icode,
  input  logic [3:0]      f_ifun,
  input  logic [3:0]      f_rA,
  input  logic [3:0]      f_rB,
  input  logic [XLEN-1:0] f_valC,
  input  logic [XLEN-1:0] f_valP,
  input  logic [2:0]      f_stat,
  input  logic            D_stall,
  input  logic            D_bubble,
  input  logic [3:0]      W_dstE,
  input  logic [XLEN-1:0] W_valE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] W_valM,
  output logic [3:0]      d_icode,
  output logic [3:0]      d_ifun,
  output logic [XLEN-1:0] d_valC,
  output logic [XLEN-1:0] d_valP,
  output logic [2:0]      d_stat,
  output logic [3:0]      d_srcA,
  output logic [3:0]      d_srcB,
  output logic [3:0]      d_dstE,
  output logic [3:0]      d_dstM,
  output logic [XLEN-1:0] d_valA,
  output logic [XLEN-1:0] d_valB
);

  d_reg_t          d_reg;
  logic [3:0]      src_a;
  logic [3:0]      src_b;
  logic [3:0]      dst_e;
  logic [3:0]      dst_m;
  logic [XLEN-1:0] rf_val_a;
  logic [XLEN-1:0] rf_val_b;

  // Pipeline register D: stall holds even when a bubble is also requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_reg <= D_BUBBLE;
    end else if (D_stall) begin
      d_reg <= d_reg;
    end else if (D_bubble) begin
      d_reg <= D_BUBBLE;
    end else begin
      d_reg <= '{
        icode: f_icode,
        ifun:  f_ifun,
        ra:    f_rA,
        rb:    f_rB,
        val_c: f_valC,
        val_p: f_valP,
        stat:  f_stat
      };
    end
  end

  // Register ID decode; invalid icodes fall to the default and name nothing.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_reg.icode)
      I_RRMOVQ: begin
        src_a = d_reg.ra;
        dst_e = d_reg.rb;
      end
      I_IRMOVQ: begin
        dst_e = d_reg.rb;
      end
      I_RMMOVQ: begin
        src_a = d_reg.ra;
        src_b = d_reg.rb;
      end
      I_MRMOVQ: begin
        src_b = d_reg.rb;
        dst_m = d_reg.ra;
      end
      I_OPQ: begin
        src_a = d_reg.ra;
        src_b = d_reg.rb;
        dst_e = d_reg.rb;
      end
      I_CALL: begin
        src_b = RSP;
        dst_e = RSP;
      end
      I_RET: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      I_PUSHQ: begin
        src_a = d_reg.ra;
        src_b = RSP;
        dst_e = RSP;
      end
      I_POPQ: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = d_reg.ra;
      end
      default: begin
      end
    endcase
  end

  y86_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .src_a (src_a),
    .src_b (src_b),
    .val_a (rf_val_a),
    .val_b (rf_val_b),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM)
  );

  // Jumps and calls carry the fall-through PC in valA instead of a register.
  always_comb begin
    d_valA = rf_val_a;
    if (d_reg.icode == I_JXX || d_reg.icode == I_CALL) begin
      d_valA = d_reg.val_p;
    end
  end

  assign d_valB  = rf_val_b;
  assign d_icode = d_reg.icode;
  assign d_ifun  = d_reg.ifun;
  assign d_valC  = d_reg.val_c;
  assign d_valP  = d_reg.val_p;
  assign d_stat  = d_reg.stat;
  assign d_srcA  = src_a;
  assign d_srcB  = src_b;
  assign d_dstE  = dst_e;
  assign d_dstM  = dst_m;

endmodule

// File: doc/y86_decode_stage.md
Name: y86_decode_stage

Overview:
- Pipelined Y86-64 decode/write-back stage, directly downstream of the fetch stage.
- Captures fetch outputs (icode, ifun, rA, rB, valC, valP, stat) into the F→D pipeline register, which supports stall and bubble.
- Owns the 15×64-bit program register file. Computes register IDs srcA, srcB, dstE, dstM and reads valA/valB for the execute stage.
- Accepts write-back from the W stage. Same-cycle write→read bypass is built in.

Parameters:
- XLEN, 64, data/PC width
- NREGS, 15, architectural registers (IDs 0x0–0xE; 0xF = RNONE)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- f_icode  in  4  instruction code from fetch
- f_ifun  in  4  function code from fetch
- f_rA  in  4  register specifier A (0xF if none)
- f_rB  in  4  register specifier B (0xF if none)
- f_valC  in  64  constant word
- f_valP  in  64  incremented PC
- f_stat  in  3  fetch status (AOK=1, HLT=2, ADR=3, INS=4)
- D_stall  in  1  hold pipeline register D
- D_bubble  in  1  load NOP into pipeline register D
- W_dstE  in  4  write-back E destination (0xF = none)
- W_valE  in  64  write-back E data
- W_dstM  in  4  write-back M destination (0xF = none)
- W_valM  in  64  write-back M data
- d_icode, d_ifun  out  4 each  registered D-stage codes
- d_valC, d_valP  out  64 each  registered constant / PC+len
- d_stat  out  3  registered status
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs
- d_valA, d_valB  out  64 each  operand values

Behaviour:
- Reset (asynchronous): D register = bubble: icode=NOP(1), ifun=0, rA=rB=0xF, valC=valP=0, stat=AOK. All 15 registers = 0. Resulting outputs: srcA/srcB/dstE/dstM=0xF, valA=valB=0.
- D register update at posedge clk, in priority order:
  - D_stall=1: hold current contents. Stall beats bubble when both are asserted.
  - else D_bubble=1: load the bubble value defined under Reset.
  - else: load the f_* inputs.
- Register ID decode (combinational from D; icodes 0 HALT, 1 NOP, 2 RRMOVQ/CMOVXX, 3 IRMOVQ, 4 RMMOVQ, 5 MRMOVQ, 6 OPQ, 7 JXX, 8 CALL, 9 RET, A PUSHQ, B POPQ; RSP=4):
  - srcA = rA for {2,4,6,A}; RSP for {9,B}; else 0xF.
  - srcB = rB for {4,5,6}; RSP for {8,9,A,B}; else 0xF.
  - dstE = rB for {2,3,6}; RSP for {8,9,A,B}; else 0xF. CMOV condition is resolved in execute.
  - dstM = rA for {5,B}; else 0xF.
  - Invalid icode (C–F): all IDs 0xF. stat passes through unchanged; the fetch stage already flags INS.
- Operand select:
  - valA = valP for {7,8}; else RF[srcA].
  - valB = RF[srcB].
  - Reading ID 0xF returns 0.
- Register file:
  - Two combinational read ports, two synchronous write ports, written at posedge clk.
  - A write to ID 0xF is ignored.
  - If W_dstE == W_dstM ≠ 0xF, valM wins (popq %rsp semantics).
- Bypass: when a read ID matches a write port in the same cycle, the read returns the incoming write data, with valM taking priority over valE. Decode therefore sees write-back data with zero cycles of delay.
- Latency: D outputs appear 1 cycle after fetch presents them. valA/valB are combinational from D and the RF/write-back inputs.
- Write-back is independent of D_stall/D_bubble; the RF updates every cycle.
- Reset asserted mid-operation: D and the RF clear immediately, without waiting for a clock edge. Write-back is suppressed while reset is high.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT…I_POPQ)
  - RNONE=4'hF, RSP=4'h4
  - stat codes S_AOK/S_HLT/S_ADR/S_INS
  - the bubble constant
- One sub-module, y86_regfile: 15×64, 2R/2W, with bypass and M-over-E priority.

Test Plan:
- Reset → d_icode=1, d_srcA=d_srcB=d_dstE=d_dstM=0xF, d_valA=d_valB=0; all 15 registers read back as 0.
- W_dstE=3, W_valE=0x1234 for one cycle; then fetch OPQ(6) with rA=rB=3 → next cycle d_srcA=d_srcB=3, d_valA=d_valB=0x1234, d_dstE=3.
- D holds RRMOVQ rA=2, and in the same cycle W_dstE=2, W_valE=0xAA → d_valA=0xAA combinationally before the edge.
- W_dstE=4 (valE=0x100) and W_dstM=4 (valM=0x55) in the same cycle → subsequent read of RSP returns 0x55.
- Fetch CALL with valP=0x20 and RSP=0x200 → d_valA=0x20, d_srcB=4, d_valB=0x200, d_dstE=4, d_dstM=0xF.
- Latch MRMOVQ, then D_stall=1 for 3 cycles while fetch changes → D outputs unchanged. Then D_bubble=1 → d_icode=1 and all IDs 0xF. D_stall=D_bubble=1 together → D holds.
